// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if : valid/ready load/store request/response bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder : fixed-latency word memory behind a valid/ready interface.
// Optional MEMRSP_ALIGN_CHECK_EN flags misaligned / out-of-range requests.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic [31:0]             mem_q [DEPTH];

  logic                    req_ready;
  logic                    accept;
  logic                    req_err;
  logic                    commit;
  logic                    c_wr;
  logic                    c_err;
  logic [ADDR_WIDTH-1:0]   c_idx;
  logic [31:0]             c_wdata;
  logic                    mem_we;

`ifdef MEMRSP_ALIGN_CHECK_EN
  assign req_err = (bus.req_addr[1:0] != 2'b00) |
                   (bus.req_addr[31:ADDR_WIDTH+2] != '0);
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[31:ADDR_WIDTH+2]};
`endif

  assign req_ready = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
  assign accept    = bus.req_valid & req_ready;

  // A commit straight from the accept cycle (LATENCY==1) must use the live
  // request, since the holding registers only load on that same edge.
  always_comb begin
    if (state_q == WAIT) begin
      c_wr    = wr_q;
      c_err   = err_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
    end else begin
      c_wr    = bus.req_wr;
      c_err   = req_err;
      c_idx   = bus.req_addr[ADDR_WIDTH+1:2];
      c_wdata = bus.req_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    commit      = 1'b0;

    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // New accepts come from IDLE or from a RESP handshake; both launch alike.
    if (accept) begin
      wr_d    = bus.req_wr;
      err_d   = req_err;
      idx_d   = bus.req_addr[ADDR_WIDTH+1:2];
      wdata_d = bus.req_wdata;
      if (LATENCY == 1) begin
        commit  = 1'b1;
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
    end

    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = c_err;
      rsp_rdata_d = (c_wr | c_err) ? 32'd0 : mem_q[c_idx];
    end
  end

  assign mem_we = commit & c_wr & ~c_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage is not reset; a store pending in WAIT is dropped by reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder : directed bench for LATENCY=2 and LATENCY=1 responders
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mem_responder_if m2 ();
  mem_responder_if m1 ();

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (m2.slave)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (m1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=2 transaction with rsp_ready high; starts just after a posedge.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int waited;
    int lat;
    m2.req_valid = 1'b1;
    m2.req_wr    = wr;
    m2.req_addr  = addr;
    m2.req_wdata = wdata;
    m2.rsp_ready = 1'b1;
    @(negedge clk);
    waited = 0;
    while (!m2.req_ready && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    check({tag, "_req_ready"}, 32'(m2.req_ready), 32'd1);
    tick();
    m2.req_valid = 1'b0;
    m2.req_wr    = 1'b0;
    m2.req_addr  = 32'hFFFF_FFFF;
    m2.req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    lat = 1;
    while (!m2.rsp_valid && lat < 20) begin
      tick();
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, m2.rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(m2.rsp_err), 32'(exp_err));
    tick();
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(m2.rsp_valid), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_d;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    m2.req_valid = 1'b0; m2.req_wr = 1'b0; m2.req_addr = 32'd0; m2.req_wdata = 32'd0; m2.rsp_ready = 1'b0;
    m1.req_valid = 1'b0; m1.req_wr = 1'b0; m1.req_addr = 32'd0; m1.req_wdata = 32'd0; m1.rsp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(m2.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(m2.rsp_valid), 32'd0);
    check("rst_rsp_rdata", m2.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(m2.rsp_err), 32'd0);
    tick();

    do_req("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_req("ld10", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_req("st20", 1'b1, 32'h20, 32'hA5A5_0020, 32'd0, 1'b0);

    // Response held under backpressure, then back-to-back accept.
    m2.req_valid = 1'b1; m2.req_wr = 1'b0; m2.req_addr = 32'h20; m2.rsp_ready = 1'b0;
    @(negedge clk);
    tick();
    m2.req_valid = 1'b0;
    @(negedge clk);
    check("bp_wait_valid", 32'(m2.rsp_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(m2.rsp_valid), 32'd1);
      check("bp_hold_rdata", m2.rsp_rdata, 32'hA5A5_0020);
      check("bp_hold_ready", 32'(m2.req_ready), 32'd0);
      tick();
    end
    m2.rsp_ready = 1'b1; m2.req_valid = 1'b1; m2.req_wr = 1'b0; m2.req_addr = 32'h10;
    @(negedge clk);
    check("b2b_req_ready", 32'(m2.req_ready), 32'd1);
    check("b2b_old_valid", 32'(m2.rsp_valid), 32'd1);
    tick();
    m2.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_gap_valid", 32'(m2.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("b2b_new_valid", 32'(m2.rsp_valid), 32'd1);
    check("b2b_new_rdata", m2.rsp_rdata, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    check("b2b_done_valid", 32'(m2.rsp_valid), 32'd0);
    tick();

    // Reset during WAIT drops an uncommitted store.
    do_req("pre40", 1'b1, 32'h40, 32'd0, 32'd0, 1'b0);
    m2.req_valid = 1'b1; m2.req_wr = 1'b1; m2.req_addr = 32'h40; m2.req_wdata = 32'h1234_5678;
    @(negedge clk);
    tick();
    m2.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rstw_wait_valid", 32'(m2.rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstw_valid", 32'(m2.rsp_valid), 32'd0);
    check("rstw_ready", 32'(m2.req_ready), 32'd1);
    tick();
    do_req("ld40_after_rst", 1'b0, 32'h40, 32'd0, 32'd0, 1'b0);

    // Misaligned store and aliased high address.
`ifdef MEMRSP_ALIGN_CHECK_EN
    do_req("st42", 1'b1, 32'h42, 32'hCAFE_F00D, 32'd0, 1'b1);
    do_req("ld40_a", 1'b0, 32'h40, 32'd0, 32'd0, 1'b0);
    do_req("st1040", 1'b1, 32'h1040, 32'h1111_2222, 32'd0, 1'b1);
    do_req("ld40_b", 1'b0, 32'h40, 32'd0, 32'd0, 1'b0);
`else
    do_req("st42", 1'b1, 32'h42, 32'hCAFE_F00D, 32'd0, 1'b0);
    do_req("ld40_a", 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D, 1'b0);
    do_req("st1040", 1'b1, 32'h1040, 32'h1111_2222, 32'd0, 1'b0);
    do_req("ld40_b", 1'b0, 32'h40, 32'd0, 32'h1111_2222, 1'b0);
`endif

    // LATENCY=1 stream: 8 stores then 8 loads in reverse word order.
    for (int k = 0; k < 17; k++) begin
      if (k < 16) begin
        m1.req_valid = 1'b1;
        m1.req_wr    = (k < 8);
        m1.req_addr  = 32'h100 + 32'(4 * ((k < 8) ? k : (15 - k)));
        m1.req_wdata = 32'h0A0B_0000 + 32'(k);
      end else begin
        m1.req_valid = 1'b0;
      end
      m1.rsp_ready = 1'b1;
      @(negedge clk);
      if (k < 16) check("l1_req_ready", 32'(m1.req_ready), 32'd1);
      if (k > 0) begin
        exp_d = (k - 1 < 8) ? 32'd0 : 32'h0A0B_0000 + 32'(15 - (k - 1));
        check("l1_rsp_valid", 32'(m1.rsp_valid), 32'd1);
        check("l1_rsp_rdata", m1.rsp_rdata, exp_d);
      end
      tick();
    end
    @(negedge clk);
    check("l1_idle_valid", 32'(m1.rsp_valid), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
